// File: rtl/cpu_step_ctrl_if.sv
// rtl/cpu_step_ctrl_if.sv - control/status signal bundle between step controller and its environment
interface cpu_step_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             tick_in;
    logic             mode_run;
    logic             step_btn;
    logic             halt;
    logic             cpu_ce;
    logic [CNT_W-1:0] cycle_cnt;
    logic [1:0]       state;
    logic             running;

    modport master (
        output tick_in, mode_run, step_btn, halt,
        input  cpu_ce, cycle_cnt, state, running
    );

    modport slave (
        input  tick_in, mode_run, step_btn, halt,
        output cpu_ce, cycle_cnt, state, running
    );
endinterface

// File: rtl/cpu_step_ctrl.sv
// rtl/cpu_step_ctrl.sv - run/single-step CPU clock-enable controller with cycle counter and halt latch
module cpu_step_ctrl #(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 32
) (
    input  logic          clk,
    input  logic          reset,
    cpu_step_ctrl_if.slave bus
);
    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10,
        S_HALT = 2'b11
    } state_t;

    logic             tick_q;
    logic [1:0]       mode_sync_q;
    logic [1:0]       btn_sync_q;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             db_lvl_q, db_lvl_d;
    logic             db_lvl_prev_q;
    state_t           state_q;
    logic             cpu_ce_q;
    logic             running_q;
    logic [CNT_W-1:0] cycle_cnt_q;

    logic tick_rise;
    logic mode_s;
    logic btn_s;
    logic step_req;

    // tick_in is already in the clk domain, so a single delay register finds its rising edge
    assign tick_rise = bus.tick_in & ~tick_q;
    assign mode_s    = mode_sync_q[1];
    assign btn_s     = btn_sync_q[1];
    assign step_req  = db_lvl_q & ~db_lvl_prev_q;

    // Debounce: accept a new button level only after it differs for DB_CYCLES consecutive cycles
    always_comb begin
        db_cnt_d = db_cnt_q;
        db_lvl_d = db_lvl_q;
        if (btn_s == db_lvl_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            db_lvl_d = btn_s;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    // Input conditioning: tick edge register, 2-FF synchronizers and debounce state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_q        <= 1'b0;
            mode_sync_q   <= 2'b00;
            btn_sync_q    <= 2'b00;
            db_cnt_q      <= '0;
            db_lvl_q      <= 1'b0;
            db_lvl_prev_q <= 1'b0;
        end else begin
            tick_q        <= bus.tick_in;
            mode_sync_q   <= {mode_sync_q[0], bus.mode_run};
            btn_sync_q    <= {btn_sync_q[0], bus.step_btn};
            db_cnt_q      <= db_cnt_d;
            db_lvl_q      <= db_lvl_d;
            db_lvl_prev_q <= db_lvl_q;
        end
    end

    // Control FSM with registered outputs; halt outranks everything and only reset leaves HALTED
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cpu_ce_q    <= 1'b0;
            running_q   <= 1'b0;
            cycle_cnt_q <= '0;
        end else begin
            cpu_ce_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.halt) begin
                        state_q   <= S_HALT;
                        running_q <= 1'b0;
                    end else if (mode_s) begin
                        // a simultaneous step request is dropped: free-run wins
                        state_q   <= S_RUN;
                        running_q <= 1'b1;
                    end else if (step_req) begin
                        state_q   <= S_STEP;
                    end
                end
                S_RUN: begin
                    if (bus.halt) begin
                        state_q   <= S_HALT;
                        running_q <= 1'b0;
                    end else if (!mode_s) begin
                        // leaving RUN suppresses a coincident tick
                        state_q   <= S_IDLE;
                        running_q <= 1'b0;
                    end else if (tick_rise) begin
                        cpu_ce_q    <= 1'b1;
                        cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
                    end
                end
                S_STEP: begin
                    if (bus.halt) begin
                        state_q   <= S_HALT;
                        running_q <= 1'b0;
                    end else if (tick_rise) begin
                        cpu_ce_q    <= 1'b1;
                        cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
                        state_q     <= S_IDLE;
                    end
                end
                S_HALT: begin
                    running_q <= 1'b0;
                end
                default: begin
                    state_q   <= S_IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cpu_ce    = cpu_ce_q;
    assign bus.cycle_cnt = cycle_cnt_q;
    assign bus.state     = state_q;
    assign bus.running   = running_q;
endmodule
